intr_ctrl: RTL and testbench
============================

INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 Parameter BASE_ADDR, default 32'h1100_0100, SHALL be the byte base address of the four-word register window.
REQ-002 Parameter NSRC, default 8 (fixed at 8 for this revision), SHALL be the number of interrupt sources.
REQ-003 CLK  input  1  SHALL be the single system clock; all state changes on its rising edge.
REQ-004 RST_N  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 IRQ  input  8  SHALL carry the asynchronous interrupt request lines; a rising edge is a request; bit 0 is highest priority.
REQ-006 INT_TAKEN  input  1  SHALL be the one-cycle pulse from the MCU control FSM indicating it has entered the interrupt vector.
REQ-007 IO_ADDR  input  32  SHALL be the IO bus byte address.
REQ-008 IO_WR  input  1  SHALL be the IO bus write strobe, valid for one cycle.
REQ-009 IO_WD  input  32  SHALL be the IO bus write data.
REQ-010 IO_RD  output  32  SHALL be the IO bus read data.
REQ-011 INTR  output  1  SHALL be the interrupt request to the MCU.

Function
REQ-012 Each IRQ bit SHALL pass through a 2-flop synchronizer and a previous-value flop; an edge SHALL be detected when synchronized=1 and previous=0.
REQ-013 An IRQ rising before edge k SHALL set PEND[i] at edge k+2; held or repeated-high levels SHALL NOT re-set the bit.
REQ-014 Register map, word-aligned, BASE_ADDR offsets: +0 PEND (read; write-1-to-clear), +4 MASK (read/write, bits [7:0]), +8 ID (read-only: bit 31 = service active, bits [2:0] = active source), +C EOI (write-only, any data).
REQ-015 IO_RD SHALL be combinational from IO_ADDR; unused bits, EOI and unmapped addresses SHALL read 0.
REQ-016 Writes SHALL take effect at the edge on which IO_WR=1 and IO_ADDR matches; non-matching writes SHALL be ignored.
REQ-017 If an edge set and a write-1-to-clear hit the same PEND bit in one cycle, set SHALL win.
REQ-018 The FSM SHALL have states IDLE, REQ and SERVICE.
REQ-019 IDLE -> REQ SHALL occur at the first edge where (PEND & MASK) != 0; pending interrupts are evaluated using the registered PEND and MASK values.
REQ-020 INTR SHALL be 1 exactly while state = REQ; INTR SHALL be decoded from the registered state, with no combinational path from IO or IRQ inputs.
REQ-021 In REQ, if (PEND & MASK) becomes 0 (W1C or mask write), the FSM SHALL return to IDLE at that edge with no ID capture.
REQ-022 In REQ, INT_TAKEN=1 SHALL, at that edge: capture the lowest index i with PEND[i]&MASK[i] into ID[2:0], set ID[31], clear PEND[i] (unless re-set per REQ-017), and enter SERVICE.
REQ-023 In SERVICE, INTR SHALL be 0 and new edges SHALL still accumulate in PEND.
REQ-024 A write to EOI in SERVICE SHALL clear ID[31] and return the FSM to IDLE at that edge; ID[2:0] SHALL hold its last value.
REQ-025 INT_TAKEN in IDLE or SERVICE SHALL be ignored.
REQ-026 EOI written in IDLE or REQ SHALL be ignored.
REQ-027 Nesting SHALL NOT be supported: at most one source is in service at a time.

Reset
REQ-028 RST_N=0 SHALL asynchronously clear the synchronizers, PEND, MASK and ID, set the state to IDLE, and drive INTR=0.
REQ-029 Reset asserted mid-REQ or mid-SERVICE SHALL abort the operation with no residual pending state.
REQ-030 After RST_N deasserts, IRQ lines already high SHALL NOT generate an edge until they return low and rise again.

Verification
REQ-031 MASK=8'h04, pulse IRQ[2] before edge k -> PEND=8'h04 at k+2, INTR=1 at k+3; INT_TAKEN -> ID reads 32'h8000_0002, PEND=0, INTR=0; EOI -> ID=32'h0000_0002, state IDLE.
REQ-032 MASK=8'hFF, IRQ[5] and IRQ[1] rise together -> INT_TAKEN captures ID=1, PEND=8'h20; after EOI, INTR reasserts next cycle; second INT_TAKEN captures ID=5.
REQ-033 MASK=0, IRQ[3] rises -> PEND=8'h08, INTR stays 0; write MASK=8'h08 -> INTR=1 one edge later; write PEND=8'h08 while in REQ -> INTR=0 and state IDLE.
REQ-034 IRQ[0] edge coincides with a W1C write of PEND bit 0 -> PEND[0] remains 1.
REQ-035 Assert RST_N=0 in SERVICE with PEND=8'h30 -> immediately INTR=0, PEND=0, MASK=0, ID=0; IRQ held high through reset release -> no PEND bit set.
REQ-036 INT_TAKEN pulsed in IDLE and EOI written in REQ -> no state, PEND or ID change.

Source files
------------

// File: rtl/intr_ctrl.sv
// Eight-source edge-triggered interrupt controller with a memory-mapped
// PEND/MASK/ID/EOI window and a single-level IDLE/REQ/SERVICE handshake.
module intr_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h1100_0100,
    parameter int          NSRC      = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NSRC-1:0] irq,
    input  logic            int_taken,
    input  logic [31:0]     io_addr,
    input  logic            io_wr,
    input  logic [31:0]     io_wd,
    output logic [31:0]     io_rd,
    output logic            intr,
    output logic [1:0]      fsm_state
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] REQ     = 2'd1;
    localparam logic [1:0] SERVICE = 2'd2;

    logic [1:0]      state, state_nxt;
    logic [NSRC-1:0] sync1, sync2, prev, armed;
    logic [1:0]      vld;
    logic [NSRC-1:0] edge_det;
    logic [NSRC-1:0] pend, pend_nxt, mask, mask_nxt, pend_masked, take_onehot;
    logic [2:0]      id_src, take_idx;
    logic            id_act;
    logic            wr_pend, wr_mask, wr_eoi, take;

    assign wr_pend = io_wr && (io_addr == BASE_ADDR);
    assign wr_mask = io_wr && (io_addr == BASE_ADDR + 32'd4);
    assign wr_eoi  = io_wr && (io_addr == BASE_ADDR + 32'd12);

    // A line only arms once it has been seen low after reset, so levels
    // already high at reset release never count as a rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
            armed <= '0;
            vld   <= '0;
        end else begin
            sync1 <= irq;
            sync2 <= sync1;
            prev  <= sync2;
            vld   <= {vld[0], 1'b1};
            armed <= armed | ({NSRC{vld[1]}} & ~sync2);
        end
    end

    assign edge_det    = sync2 & ~prev & armed;
    assign pend_masked = pend & mask;
    assign take        = (state == REQ) && int_taken && (pend_masked != '0);

    always_comb begin
        take_idx = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (pend_masked[i]) take_idx = i[2:0];
        end
    end

    assign take_onehot = NSRC'(1) << take_idx;
    assign mask_nxt    = wr_mask ? io_wd[NSRC-1:0] : mask;

    // Edge set is applied last so it wins over W1C and the take clear.
    always_comb begin
        pend_nxt = pend;
        if (wr_pend) pend_nxt = pend_nxt & ~io_wd[NSRC-1:0];
        if (take)    pend_nxt = pend_nxt & ~take_onehot;
        pend_nxt = pend_nxt | edge_det;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pend_masked != '0) state_nxt = REQ;
            REQ: begin
                if (take)                              state_nxt = SERVICE;
                else if ((pend_nxt & mask_nxt) == '0)  state_nxt = IDLE;
            end
            SERVICE: if (wr_eoi) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            pend   <= '0;
            mask   <= '0;
            id_src <= '0;
            id_act <= 1'b0;
        end else begin
            state <= state_nxt;
            pend  <= pend_nxt;
            mask  <= mask_nxt;
            if (take) begin
                id_src <= take_idx;
                id_act <= 1'b1;
            end else if ((state == SERVICE) && wr_eoi) begin
                id_act <= 1'b0;
            end
        end
    end

    assign intr      = (state == REQ);
    assign fsm_state = state;

    always_comb begin
        io_rd = '0;
        if (io_addr == BASE_ADDR)                io_rd[NSRC-1:0] = pend;
        else if (io_addr == BASE_ADDR + 32'd4)   io_rd[NSRC-1:0] = mask;
        else if (io_addr == BASE_ADDR + 32'd8)   io_rd = {id_act, 28'd0, id_src};
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// Scenario-driven bench for intr_ctrl; captured IDs are scored against a
// queue of sources expected in priority order.
module tb_intr_ctrl;

    localparam logic [31:0] A_PEND = 32'h1100_0100;
    localparam logic [31:0] A_MASK = 32'h1100_0104;
    localparam logic [31:0] A_ID   = 32'h1100_0108;
    localparam logic [31:0] A_EOI  = 32'h1100_010C;
    localparam logic [1:0]  S_IDLE = 2'd0;
    localparam logic [1:0]  S_REQ  = 2'd1;
    localparam logic [1:0]  S_SVC  = 2'd2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  irq = '0;
    logic        int_taken = 1'b0;
    logic [31:0] io_addr = '0;
    logic        io_wr = 1'b0;
    logic [31:0] io_wd = '0;
    logic [31:0] io_rd;
    logic        intr;
    logic [1:0]  fsm_state;

    int checks = 0;
    int errors = 0;
    logic [2:0] exp_q[$];

    intr_ctrl dut (
        .clk(clk), .rst_n(rst_n), .irq(irq), .int_taken(int_taken),
        .io_addr(io_addr), .io_wr(io_wr), .io_wd(io_wd), .io_rd(io_rd),
        .intr(intr), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        io_addr = a;
        #1;
        d = io_rd;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        io_addr = a;
        io_wd   = d;
        io_wr   = 1'b1;
        tick();
        io_wr   = 1'b0;
    endtask

    task automatic wait_intr(input int max);
        int n = 0;
        while (!intr && n < max) begin
            tick();
            n++;
        end
        checks++;
        if (intr !== 1'b1) begin
            errors++;
            $display("FAIL wait_intr: intr=%b after %0d cycles, required 1", intr, n);
        end
    endtask

    task automatic take_and_score(input string name);
        logic [31:0] d;
        logic [2:0]  e;
        int_taken = 1'b1;
        tick();
        int_taken = 1'b0;
        rd(A_ID, d);
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: id=%h captured with empty expected queue", name, d);
        end else begin
            e = exp_q.pop_front();
            if (d !== {1'b1, 28'd0, e}) begin
                errors++;
                $display("FAIL %s: id=%h, required %h", name, d, {1'b1, 28'd0, e});
            end
        end
    endtask

    task automatic test_reset;
        logic [31:0] d;
        #3;
        checks++; if (intr !== 1'b0) begin errors++; $display("FAIL reset_intr: %b, required 0", intr); end
        checks++; if (fsm_state !== S_IDLE) begin errors++; $display("FAIL reset_state: %0d, required 0", fsm_state); end
        rd(A_PEND, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_pend: %h, required 0", d); end
        rd(A_MASK, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_mask: %h, required 0", d); end
        rd(A_ID, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_id: %h, required 0", d); end
        tick(2);
        rst_n = 1'b1;
        tick(4);
        wr(A_MASK, 32'hFFFF_FF5A);
        rd(A_MASK, d);
        checks++; if (d !== 32'h0000_005A) begin errors++; $display("FAIL mask_rw: %h, required 5a", d); end
        rd(A_EOI, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL eoi_read: %h, required 0", d); end
        rd(A_PEND + 32'h10, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped_read: %h, required 0", d); end
        wr(A_MASK, 32'h0);
    endtask

    task automatic test_basic;
        logic [31:0] d;
        wr(A_MASK, 32'h04);
        irq[2] = 1'b1;
        exp_q.push_back(3'd2);
        tick(2);
        rd(A_PEND, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL basic_pend_early: %h, required 0", d); end
        tick();
        rd(A_PEND, d);
        checks++; if (d !== 32'h04) begin errors++; $display("FAIL basic_pend_k2: %h, required 04", d); end
        checks++; if (intr !== 1'b0) begin errors++; $display("FAIL basic_intr_k2: %b, required 0", intr); end
        tick();
        checks++; if (intr !== 1'b1) begin errors++; $display("FAIL basic_intr_k3: %b, required 1", intr); end
        take_and_score("basic_take");
        rd(A_PEND, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL basic_pend_taken: %h, required 0", d); end
        checks++; if (intr !== 1'b0) begin errors++; $display("FAIL basic_intr_svc: %b, required 0", intr); end
        tick(3);
        rd(A_PEND, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL basic_held_level: %h, required 0", d); end
        wr(A_EOI, 32'h1234_5678);
        rd(A_ID, d);
        checks++; if (d !== 32'h0000_0002) begin errors++; $display("FAIL basic_id_eoi: %h, required 00000002", d); end
        checks++; if (fsm_state !== S_IDLE) begin errors++; $display("FAIL basic_state_eoi: %0d, required 0", fsm_state); end
        irq = '0;
        tick(3);
    endtask

    task automatic test_priority;
        logic [31:0] d;
        wr(A_MASK, 32'hFF);
        irq[5] = 1'b1;
        irq[1] = 1'b1;
        exp_q.push_back(3'd1);
        exp_q.push_back(3'd5);
        wait_intr(10);
        take_and_score("prio_first");
        rd(A_PEND, d);
        checks++; if (d !== 32'h20) begin errors++; $display("FAIL prio_pend: %h, required 20", d); end
        wr(A_EOI, 32'h0);
        checks++; if (intr !== 1'b0) begin errors++; $display("FAIL prio_intr_eoi: %b, required 0", intr); end
        tick();
        checks++; if (intr !== 1'b1) begin errors++; $display("FAIL prio_reassert: %b, required 1", intr); end
        take_and_score("prio_second");
        wr(A_EOI, 32'h0);
        irq = '0;
        tick(3);
    endtask

    task automatic test_mask;
        logic [31:0] d;
        wr(A_MASK, 32'h0);
        irq[3] = 1'b1;
        tick(4);
        rd(A_PEND, d);
        checks++; if (d !== 32'h08) begin errors++; $display("FAIL mask_pend: %h, required 08", d); end
        checks++; if (intr !== 1'b0) begin errors++; $display("FAIL mask_intr_off: %b, required 0", intr); end
        wr(A_MASK, 32'h08);
        tick();
        checks++; if (intr !== 1'b1) begin errors++; $display("FAIL mask_intr_on: %b, required 1", intr); end
        wr(A_PEND, 32'h08);
        checks++; if (intr !== 1'b0) begin errors++; $display("FAIL mask_w1c_intr: %b, required 0", intr); end
        checks++; if (fsm_state !== S_IDLE) begin errors++; $display("FAIL mask_w1c_state: %0d, required 0", fsm_state); end
        rd(A_PEND, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL mask_w1c_pend: %h, required 0", d); end
        irq = '0;
        tick(3);
    endtask

    task automatic test_collision;
        logic [31:0] d;
        wr(A_MASK, 32'h0);
        irq[0] = 1'b1;
        tick(3);
        rd(A_PEND, d);
        checks++; if (d !== 32'h01) begin errors++; $display("FAIL coll_pre: %h, required 01", d); end
        irq[0] = 1'b0;
        tick(3);
        irq[0] = 1'b1;
        tick(2);
        wr(A_PEND, 32'h01);
        rd(A_PEND, d);
        checks++; if (d !== 32'h01) begin errors++; $display("FAIL coll_set_wins: %h, required 01", d); end
        wr(A_PEND, 32'h01);
        rd(A_PEND, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL coll_plain_w1c: %h, required 0", d); end
        irq = '0;
        tick(3);
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        wr(A_MASK, 32'hFF);
        irq[0] = 1'b1;
        exp_q.push_back(3'd0);
        wait_intr(10);
        take_and_score("rst_take");
        irq[0] = 1'b0;
        irq[5:4] = 2'b11;
        tick(4);
        rd(A_PEND, d);
        checks++; if (d !== 32'h30) begin errors++; $display("FAIL rst_svc_pend: %h, required 30", d); end
        checks++; if (fsm_state !== S_SVC || intr !== 1'b0) begin
            errors++; $display("FAIL rst_svc_state: state=%0d intr=%b, required 2/0", fsm_state, intr);
        end
        rst_n = 1'b0;
        #1;
        checks++; if (intr !== 1'b0 || fsm_state !== S_IDLE) begin
            errors++; $display("FAIL rst_async: intr=%b state=%0d, required 0/0", intr, fsm_state);
        end
        rd(A_PEND, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_pend: %h, required 0", d); end
        rd(A_MASK, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_mask: %h, required 0", d); end
        rd(A_ID, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_id: %h, required 0", d); end
        tick(2);
        rst_n = 1'b1;
        tick(6);
        rd(A_PEND, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_held_high: %h, required 0", d); end
        irq[5:4] = 2'b00;
        tick(3);
        irq[4] = 1'b1;
        tick(4);
        rd(A_PEND, d);
        checks++; if (d !== 32'h10) begin errors++; $display("FAIL rst_rearm: %h, required 10", d); end
        irq = '0;
        wr(A_PEND, 32'hFF);
        tick(3);
    endtask

    task automatic test_ignore;
        logic [31:0] d;
        int_taken = 1'b1;
        tick();
        int_taken = 1'b0;
        checks++; if (fsm_state !== S_IDLE) begin errors++; $display("FAIL ign_take_state: %0d, required 0", fsm_state); end
        rd(A_ID, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL ign_take_id: %h, required 0", d); end
        wr(A_MASK, 32'h40);
        irq[6] = 1'b1;
        exp_q.push_back(3'd6);
        wait_intr(10);
        wr(A_EOI, 32'h0);
        checks++; if (fsm_state !== S_REQ || intr !== 1'b1) begin
            errors++; $display("FAIL ign_eoi_state: state=%0d intr=%b, required 1/1", fsm_state, intr);
        end
        rd(A_PEND, d);
        checks++; if (d !== 32'h40) begin errors++; $display("FAIL ign_eoi_pend: %h, required 40", d); end
        rd(A_ID, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL ign_eoi_id: %h, required 0", d); end
        take_and_score("ign_take");
        int_taken = 1'b1;
        tick();
        int_taken = 1'b0;
        checks++; if (fsm_state !== S_SVC) begin errors++; $display("FAIL ign_svc_take: %0d, required 2", fsm_state); end
        wr(A_EOI, 32'h0);
        rd(A_ID, d);
        checks++; if (d !== 32'h6 || fsm_state !== S_IDLE) begin
            errors++; $display("FAIL ign_final: id=%h state=%0d, required 6/0", d, fsm_state);
        end
        irq = '0;
        tick(3);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_mask();
        test_collision();
        test_reset_mid();
        test_ignore();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
